div_seq_ctrl: RTL and testbench

Multi-cycle unsigned 32-bit restoring divider. It sequences one instance of the team's 32-bit ripple-borrow subtractor, retiring one quotient bit per cycle. It sits beside the ALU as the DIV/REM execution unit. Operands are accepted and results returned over valid/ready handshakes.

---
 rtl/div_seq_ctrl_pkg.sv | 17 +
 rtl/div_seq_ctrl_sub.sv | 24 ++
 rtl/div_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_div_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// datapath width, divide-by-zero quotient and the iteration counter limit.
package div_seq_ctrl_pkg;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT_DEF = 32'hFFFF_FFFF;

  localparam int CNT_WIDTH = 5;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_seq_ctrl_sub.sv
// 32-bit ripple-borrow subtractor: result = a_i - b_i, bout_o set when a_i < b_i.
module div_seq_ctrl_sub
  import div_seq_ctrl_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a_i,
  input  logic [DIV_WIDTH-1:0] b_i,
  output logic [DIV_WIDTH-1:0] result_o,
  output logic                 bout_o
);

  logic borrow;

  // Walk the borrow from the LSB upward, one full-subtractor cell per bit.
  always_comb begin
    result_o = '0;
    borrow   = 1'b0;
    for (int i = 0; i < DIV_WIDTH; i++) begin
      result_o[i] = a_i[i] ^ b_i[i] ^ borrow;
      borrow      = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow);
    end
    bout_o = borrow;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned restoring divider. One quotient bit is retired per
// cycle through a single shared subtractor; operands and results move over
// valid/ready handshakes. Divide-by-zero bypasses the iteration loop.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int                   WIDTH     = DIV_WIDTH,
  parameter logic [DIV_WIDTH-1:0] DIV0_QUOT = DIV0_QUOT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  state_e                state_q, state_d;
  logic                  inReady_q, inReady_d;
  logic [WIDTH-1:0]      dvd_q, dvd_d;
  logic [WIDTH-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]      dsr_q, dsr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]      quotOut_q, quotOut_d;
  logic [WIDTH-1:0]      remOut_q, remOut_d;
  logic                  divZero_q, divZero_d;

  logic [WIDTH-1:0]      trialLow;
  logic                  carryBit;
  logic [WIDTH-1:0]      diffVal;
  logic                  borrowOut;
  logic                  iterOk;
  logic [WIDTH-1:0]      remNext;
  logic [WIDTH-1:0]      quotNext;

  // The 33-bit trial value is {carryBit, trialLow}; only the low 32 bits go
  // through the subtractor because a set carry guarantees success anyway.
  assign trialLow = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign carryBit = rem_q[WIDTH-1];

  div_seq_ctrl_sub u_sub (
    .a_i      (trialLow),
    .b_i      (dsr_q),
    .result_o (diffVal),
    .bout_o   (borrowOut)
  );

  assign iterOk   = carryBit | ~borrowOut;
  assign remNext  = iterOk ? diffVal : trialLow;
  assign quotNext = {dvd_q[WIDTH-2:0], iterOk};

  assign in_ready  = inReady_q;
  assign out_valid = (state_q == ST_DONE);
  assign quotient  = quotOut_q;
  assign remainder = remOut_q;
  assign div_zero  = divZero_q;

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      inReady_q <= 1'b0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      quotOut_q <= '0;
      remOut_q  <= '0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inReady_q <= inReady_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      cnt_q     <= cnt_d;
      quotOut_q <= quotOut_d;
      remOut_q  <= remOut_d;
      divZero_q <= divZero_d;
    end
  end

  // Next-state logic: accept in IDLE, iterate in RUN, hold results in DONE.
  always_comb begin
    state_d   = state_q;
    inReady_d = 1'b0;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    quotOut_d = quotOut_q;
    remOut_d  = remOut_q;
    divZero_d = divZero_q;
    case (state_q)
      ST_IDLE: begin
        inReady_d = 1'b1;
        if (in_valid && inReady_q) begin
          inReady_d = 1'b0;
          if (divisor == '0) begin
            quotOut_d = DIV0_QUOT;
            remOut_d  = dividend;
            divZero_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            dvd_d   = dividend;
            dsr_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        rem_d = remNext;
        dvd_d = quotNext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          quotOut_d = quotNext;
          remOut_d  = remNext;
          divZero_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          inReady_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed corner cases followed by
// randomized operands compared against plain '/' and '%' arithmetic.
module tb_div_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  div_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the handshake protocol deadlocks.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one operation end to end: waits for in_ready, accepts, measures
  // latency, checks the result, optionally stalls out_ready, then hands off.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int stall, input bit junk);
    logic [31:0] expQ, expR;
    logic        expZ;
    int          wait_cnt;
    int          lat;
    if (b == 32'd0) begin
      expQ = 32'hFFFF_FFFF;
      expR = a;
      expZ = 1'b1;
    end else begin
      expQ = a / b;
      expR = a % b;
      expZ = 1'b0;
    end
    out_ready = (stall == 0);
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 60) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && junk) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor  = $urandom;
      end else begin
        in_valid = 1'b0;
      end
    end while (!out_valid && lat < 100);
    in_valid = 1'b0;
    checkOutput("latency", lat, (b == 32'd0) ? 32'd1 : 32'd33);
    checkOutput("quotient", quotient, expQ);
    checkOutput("remainder", remainder, expR);
    checkOutput("div_zero", {31'd0, div_zero}, {31'd0, expZ});
    checkOutput("in_ready_busy", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = $urandom;
      divisor  = $urandom;
      @(negedge clk);
      checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_quotient", quotient, expQ);
      checkOutput("stall_remainder", remainder, expR);
      checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    checkOutput("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    checkOutput("quotient_held", quotient, expQ);
  endtask

  // Starts a division and pulls reset partway through the iterations.
  task automatic midRunReset(input logic [31:0] a, input logic [31:0] b);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 60) begin
      @(negedge clk);
      wait_cnt++;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_quotient", quotient, 32'd0);
    checkOutput("rst_remainder", remainder, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_release_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  // Directed scenarios first, then randomized operand pairs.
  initial begin
    logic [31:0] a, b;
    int          stall;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    #2;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    checkOutput("reset_div_zero", {31'd0, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(32'd100, 32'd7, 0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0001, 0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    applyStimulus(32'd12345, 32'd0, 0, 1'b0);
    applyStimulus(32'd5, 32'd9, 0, 1'b0);
    applyStimulus(32'd0, 32'd3, 0, 1'b0);
    applyStimulus(32'd1000, 32'd3, 10, 1'b1);
    applyStimulus(32'd77, 32'd0, 10, 1'b1);
    midRunReset(32'd100, 32'd7);
    applyStimulus(32'd50, 32'd5, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 19) == 0) b = 32'd0;
      stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      applyStimulus(a, b, stall, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
